// File: rtl/axi_slave_pkg.sv
// axi_slave_pkg
// Shared definitions for the AXI RAM slave: response and burst codes,
// write/read FSM state encodings and the response "worst-of" merge.
package axi_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // The slave only ever produces OKAY, SLVERR or DECERR, whose encodings
  // are already ordered by severity, so the numerically larger code wins.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_ram_dp.sv
// axi_ram_dp
// Simple dual-port 32-bit RAM with per-byte write enables and a registered,
// read-first read port. Contents are never reset.
// Ports:
//   clk                         clock
//   wr_en/wr_addr/wr_data/wr_strb  write port (byte lanes selected by wr_strb)
//   rd_en/rd_addr               read request; rd_data updates only when rd_en=1
//   rd_data                     registered read data
module axi_ram_dp #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_strb,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [0:(1<<AW)-1];

  // Both ports sample the array before this edge's write lands, so a
  // same-word read and write returns the old word. The read register only
  // loads on request, which keeps a stalled beat stable even if the word
  // underneath is rewritten.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axi_slave_ram_responder.sv
// axi_slave_ram_responder
// AXI slave endpoint backed by an on-chip RAM. Independent write
// (AW -> W -> B) and read (AR -> R) engines share one dual-port RAM.
// Ports:
//   CLK, RST                         clock, asynchronous active-high reset
//   WR_ADDR_* / WR_ADDR_VALID/READY  write-address channel
//   WR_DATA/WR_STRB/WR_DATA_LAST     write-data channel with VALID/READY
//   WR_BACK_ID/WR_BACK_RESP          write-response channel with VALID/READY
//   RD_ADDR_* / RD_ADDR_VALID/READY  read-address channel
//   RD_BACK_ID/RD_DATA/RD_DATA_RESP/RD_DATA_LAST  read-data channel with VALID/READY
module axi_slave_ram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_AW    = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  WR_ADDR_ID,
  input  logic [31:0] WR_ADDR,
  input  logic [7:0]  WR_ADDR_LEN,
  input  logic [1:0]  WR_ADDR_BURST,
  input  logic        WR_ADDR_VALID,
  output logic        WR_ADDR_READY,
  input  logic [31:0] WR_DATA,
  input  logic [3:0]  WR_STRB,
  input  logic        WR_DATA_LAST,
  input  logic        WR_DATA_VALID,
  output logic        WR_DATA_READY,
  output logic [3:0]  WR_BACK_ID,
  output logic [1:0]  WR_BACK_RESP,
  output logic        WR_BACK_VALID,
  input  logic        WR_BACK_READY,
  input  logic [3:0]  RD_ADDR_ID,
  input  logic [31:0] RD_ADDR,
  input  logic [7:0]  RD_ADDR_LEN,
  input  logic [1:0]  RD_ADDR_BURST,
  input  logic        RD_ADDR_VALID,
  output logic        RD_ADDR_READY,
  output logic [3:0]  RD_BACK_ID,
  output logic [31:0] RD_DATA,
  output logic [1:0]  RD_DATA_RESP,
  output logic        RD_DATA_LAST,
  output logic        RD_DATA_VALID,
  input  logic        RD_DATA_READY
);

  import axi_slave_pkg::*;

  // Size of the decoded window in bytes; one extra bit so the compare
  // cannot overflow.
  localparam logic [32:0] SPAN = 33'd4 << MEM_AW;

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
  endfunction

  function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE_ADDR) >> 2;
    return MEM_AW'(off);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? a : a + 32'd4;
  endfunction

  // Decode errors outrank the reserved-burst error.
  function automatic logic [1:0] beat_resp(input logic [31:0] a, input logic [1:0] burst);
    if (!in_range(a)) return RESP_DECERR;
    return burst[1] ? RESP_SLVERR : RESP_OKAY;
  endfunction

  // Holds both address READYs low during reset and releases them on the
  // first edge afterwards.
  logic live;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) live <= 1'b0;
    else     live <= 1'b1;
  end

  logic              ram_wr_en;
  logic [MEM_AW-1:0] ram_wr_addr;
  logic              ram_rd_en;
  logic [MEM_AW-1:0] ram_rd_addr;
  logic [31:0]       ram_q;

  axi_ram_dp #(.AW(MEM_AW)) u_ram (
    .clk     (CLK),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (WR_DATA),
    .wr_strb (WR_STRB),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_q)
  );

  // ---------------- write engine ----------------
  wr_state_t   w_state, w_state_nxt;
  logic [3:0]  w_id;
  logic [31:0] w_addr;
  logic [7:0]  w_len, w_cnt;
  logic [1:0]  w_burst, w_resp, w_beat_resp;
  logic        w_over;
  logic        aw_hs, w_hs, b_hs;

  assign aw_hs = WR_ADDR_VALID && WR_ADDR_READY;
  assign w_hs  = WR_DATA_VALID && WR_DATA_READY;
  assign b_hs  = WR_BACK_VALID && WR_BACK_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && WR_DATA_LAST) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    WR_ADDR_READY = live && (w_state == W_IDLE);
    WR_DATA_READY = (w_state == W_DATA);
    WR_BACK_VALID = (w_state == W_RESP);
    WR_BACK_ID    = WR_BACK_VALID ? w_id   : 4'd0;
    WR_BACK_RESP  = WR_BACK_VALID ? w_resp : 2'd0;
  end

  // Beats past the announced length are swallowed as SLVERR; a LAST that
  // arrives before the announced length also flags SLVERR.
  always_comb begin
    w_beat_resp = w_over ? RESP_SLVERR : beat_resp(w_addr, w_burst);
    if (WR_DATA_LAST && !w_over && (w_cnt != w_len))
      w_beat_resp = resp_worst(w_beat_resp, RESP_SLVERR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_over  <= 1'b0;
      w_resp  <= RESP_OKAY;
    end else if (aw_hs) begin
      w_id    <= WR_ADDR_ID;
      w_addr  <= WR_ADDR;
      w_len   <= WR_ADDR_LEN;
      w_burst <= WR_ADDR_BURST;
      w_cnt   <= '0;
      w_over  <= 1'b0;
      w_resp  <= RESP_OKAY;
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_burst);
      w_cnt  <= w_cnt + 8'd1;
      if (!WR_DATA_LAST && (w_cnt == w_len)) w_over <= 1'b1;
      w_resp <= resp_worst(w_resp, w_beat_resp);
    end
  end

  assign ram_wr_en   = w_hs && !w_over && in_range(w_addr);
  assign ram_wr_addr = word_idx(w_addr);

  // ---------------- read engine ----------------
  rd_state_t   r_state, r_state_nxt;
  logic [3:0]  r_id;
  logic [31:0] r_addr, r_addr_nxt;
  logic [7:0]  r_len, r_cnt;
  logic [1:0]  r_burst;
  logic        ar_hs, r_hs, r_last;

  assign ar_hs      = RD_ADDR_VALID && RD_ADDR_READY;
  assign r_hs       = RD_DATA_VALID && RD_DATA_READY;
  assign r_last     = (r_cnt == r_len);
  assign r_addr_nxt = next_addr(r_addr, r_burst);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && r_last) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    RD_ADDR_READY = live && (r_state == R_IDLE);
    RD_DATA_VALID = (r_state == R_DATA);
    RD_BACK_ID    = RD_DATA_VALID ? r_id : 4'd0;
    RD_DATA       = (RD_DATA_VALID && in_range(r_addr)) ? ram_q : 32'd0;
    RD_DATA_RESP  = RD_DATA_VALID ? beat_resp(r_addr, r_burst) : 2'd0;
    RD_DATA_LAST  = RD_DATA_VALID && r_last;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
    end else if (ar_hs) begin
      r_id    <= RD_ADDR_ID;
      r_addr  <= RD_ADDR;
      r_len   <= RD_ADDR_LEN;
      r_burst <= RD_ADDR_BURST;
      r_cnt   <= '0;
    end else if (r_hs && !r_last) begin
      r_addr <= r_addr_nxt;
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  // Prefetch the following beat on the same edge the current one is taken,
  // giving one beat per cycle while the master keeps READY high.
  assign ram_rd_en   = ar_hs || (r_hs && !r_last);
  assign ram_rd_addr = (r_state == R_IDLE) ? word_idx(RD_ADDR)
                                           : word_idx(r_hs ? r_addr_nxt : r_addr);

endmodule

// File: tb/tb_axi_slave_ram_responder.sv
// tb_axi_slave_ram_responder
// Directed bench for axi_slave_ram_responder with hand-computed expectations.
module tb_axi_slave_ram_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  WR_ADDR_ID = '0;
  logic [31:0] WR_ADDR = '0;
  logic [7:0]  WR_ADDR_LEN = '0;
  logic [1:0]  WR_ADDR_BURST = '0;
  logic        WR_ADDR_VALID = 1'b0;
  logic        WR_ADDR_READY;
  logic [31:0] WR_DATA = '0;
  logic [3:0]  WR_STRB = '0;
  logic        WR_DATA_LAST = 1'b0;
  logic        WR_DATA_VALID = 1'b0;
  logic        WR_DATA_READY;
  logic [3:0]  WR_BACK_ID;
  logic [1:0]  WR_BACK_RESP;
  logic        WR_BACK_VALID;
  logic        WR_BACK_READY = 1'b0;
  logic [3:0]  RD_ADDR_ID = '0;
  logic [31:0] RD_ADDR = '0;
  logic [7:0]  RD_ADDR_LEN = '0;
  logic [1:0]  RD_ADDR_BURST = '0;
  logic        RD_ADDR_VALID = 1'b0;
  logic        RD_ADDR_READY;
  logic [3:0]  RD_BACK_ID;
  logic [31:0] RD_DATA;
  logic [1:0]  RD_DATA_RESP;
  logic        RD_DATA_LAST;
  logic        RD_DATA_VALID;
  logic        RD_DATA_READY = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] wdat [16];
  logic [31:0] rdat [16];
  logic [1:0]  rresp [16];
  logic        rlast [16];
  int          rcyc [16];
  int          rbeats;
  logic [3:0]  rid;
  logic [3:0]  bid;
  logic [1:0]  bresp;

  axi_slave_ram_responder dut (
    .CLK(CLK), .RST(RST),
    .WR_ADDR_ID(WR_ADDR_ID), .WR_ADDR(WR_ADDR), .WR_ADDR_LEN(WR_ADDR_LEN),
    .WR_ADDR_BURST(WR_ADDR_BURST), .WR_ADDR_VALID(WR_ADDR_VALID), .WR_ADDR_READY(WR_ADDR_READY),
    .WR_DATA(WR_DATA), .WR_STRB(WR_STRB), .WR_DATA_LAST(WR_DATA_LAST),
    .WR_DATA_VALID(WR_DATA_VALID), .WR_DATA_READY(WR_DATA_READY),
    .WR_BACK_ID(WR_BACK_ID), .WR_BACK_RESP(WR_BACK_RESP),
    .WR_BACK_VALID(WR_BACK_VALID), .WR_BACK_READY(WR_BACK_READY),
    .RD_ADDR_ID(RD_ADDR_ID), .RD_ADDR(RD_ADDR), .RD_ADDR_LEN(RD_ADDR_LEN),
    .RD_ADDR_BURST(RD_ADDR_BURST), .RD_ADDR_VALID(RD_ADDR_VALID), .RD_ADDR_READY(RD_ADDR_READY),
    .RD_BACK_ID(RD_BACK_ID), .RD_DATA(RD_DATA), .RD_DATA_RESP(RD_DATA_RESP),
    .RD_DATA_LAST(RD_DATA_LAST), .RD_DATA_VALID(RD_DATA_VALID), .RD_DATA_READY(RD_DATA_READY)
  );

  // 100 MHz-style free-running clock.
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Full write burst: beats come from wdat[], LAST on beat nbeats-1.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] strb, input int nbeats);
    int n;
    @(negedge CLK);
    WR_ADDR_ID = id; WR_ADDR = addr; WR_ADDR_LEN = len; WR_ADDR_BURST = burst;
    WR_ADDR_VALID = 1'b1;
    n = 0;
    while (!WR_ADDR_READY && n < 50) begin @(negedge CLK); n++; end
    checkOutput("aw ready", WR_ADDR_READY, 1);
    @(posedge CLK); @(negedge CLK);
    WR_ADDR_VALID = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      WR_DATA = wdat[b]; WR_STRB = strb; WR_DATA_LAST = (b == nbeats - 1);
      WR_DATA_VALID = 1'b1;
      n = 0;
      while (!WR_DATA_READY && n < 50) begin @(negedge CLK); n++; end
      checkOutput("w ready", WR_DATA_READY, 1);
      @(posedge CLK); @(negedge CLK);
    end
    WR_DATA_VALID = 1'b0; WR_DATA_LAST = 1'b0;
    WR_BACK_READY = 1'b1;
    n = 0;
    while (!WR_BACK_VALID && n < 50) begin @(negedge CLK); n++; end
    checkOutput("b valid", WR_BACK_VALID, 1);
    bid = WR_BACK_ID; bresp = WR_BACK_RESP;
    @(posedge CLK); @(negedge CLK);
    WR_BACK_READY = 1'b0;
  endtask

  // Full read burst; optionally stalls RD_DATA_READY at random and checks
  // that a stalled beat does not change before it is taken.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit stall);
    int n, cyc;
    bit done, held, rdy;
    logic [31:0] hdata;
    logic hlast;
    @(negedge CLK);
    RD_ADDR_ID = id; RD_ADDR = addr; RD_ADDR_LEN = len; RD_ADDR_BURST = burst;
    RD_ADDR_VALID = 1'b1;
    n = 0;
    while (!RD_ADDR_READY && n < 50) begin @(negedge CLK); n++; end
    checkOutput("ar ready", RD_ADDR_READY, 1);
    @(posedge CLK); @(negedge CLK);
    RD_ADDR_VALID = 1'b0;
    rbeats = 0; cyc = 0; done = 0; held = 0; hdata = '0; hlast = 1'b0;
    while (!done && cyc < 200) begin
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      RD_DATA_READY = rdy;
      if (RD_DATA_VALID) begin
        if (held) begin
          checkOutput("hold data", RD_DATA, hdata);
          checkOutput("hold last", RD_DATA_LAST, hlast);
        end
        if (rdy) begin
          if (rbeats < 16) begin
            rdat[rbeats] = RD_DATA; rresp[rbeats] = RD_DATA_RESP;
            rlast[rbeats] = RD_DATA_LAST; rcyc[rbeats] = cyc;
          end
          rid = RD_BACK_ID;
          rbeats++;
          if (RD_DATA_LAST) done = 1;
          held = 0;
        end else begin
          held = 1; hdata = RD_DATA; hlast = RD_DATA_LAST;
        end
      end
      @(posedge CLK); @(negedge CLK);
      cyc++;
    end
    RD_DATA_READY = 1'b0;
    checkOutput("read done", done, 1);
  endtask

  task automatic applyStimulus();
    // Reset state and release timing.
    #1;
    checkOutput("rst awready", WR_ADDR_READY, 0);
    checkOutput("rst arready", RD_ADDR_READY, 0);
    checkOutput("rst bvalid", WR_BACK_VALID, 0);
    checkOutput("rst rvalid", RD_DATA_VALID, 0);
    @(negedge CLK); @(negedge CLK);
    checkOutput("rst arready held", RD_ADDR_READY, 0);
    RST = 1'b0;
    #1;
    checkOutput("rel awready pre-edge", WR_ADDR_READY, 0);
    @(negedge CLK);
    checkOutput("rel awready", WR_ADDR_READY, 1);
    checkOutput("rel arready", RD_ADDR_READY, 1);
    checkOutput("idle rdata", RD_DATA, 0);
    checkOutput("idle bid", WR_BACK_ID, 0);

    // INCR burst of four then read back with READY held high.
    for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
    do_write(4'd5, 32'h10, 8'd3, 2'b01, 4'hF, 4);
    checkOutput("t1 bresp", bresp, 2'b00);
    checkOutput("t1 bid", bid, 4'd5);
    do_read(4'd9, 32'h10, 8'd3, 2'b01, 0);
    checkOutput("t1 beats", rbeats, 4);
    checkOutput("t1 rid", rid, 4'd9);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t1 rdata", rdat[i], 32'(i + 1));
      checkOutput("t1 rlast", rlast[i], (i == 3) ? 1 : 0);
      checkOutput("t1 rresp", rresp[i], 2'b00);
      checkOutput("t1 no bubble", rcyc[i], i);
    end

    // Byte strobes over an all-ones word.
    wdat[0] = 32'hFFFF_FFFF;
    do_write(4'd1, 32'h0, 8'd0, 2'b01, 4'hF, 1);
    wdat[0] = 32'hAABB_CCDD;
    do_write(4'd1, 32'h0, 8'd0, 2'b01, 4'b0101, 1);
    checkOutput("t2 bresp", bresp, 2'b00);
    do_read(4'd2, 32'h0, 8'd0, 2'b01, 0);
    checkOutput("t2 rdata", rdat[0], 32'hFFBB_FFDD);
    checkOutput("t2 rlast", rlast[0], 1);

    // FIXED burst hits one word; its neighbour stays put.
    wdat[0] = 32'h1234_5678;
    do_write(4'd1, 32'h24, 8'd0, 2'b01, 4'hF, 1);
    wdat[0] = 32'd5; wdat[1] = 32'd6; wdat[2] = 32'd7;
    do_write(4'd3, 32'h20, 8'd2, 2'b00, 4'hF, 3);
    checkOutput("t3 bresp", bresp, 2'b00);
    do_read(4'd3, 32'h20, 8'd1, 2'b01, 0);
    checkOutput("t3 word20", rdat[0], 32'd7);
    checkOutput("t3 word24", rdat[1], 32'h1234_5678);

    // First address past the window: DECERR and no aliasing onto word 0.
    wdat[0] = 32'hDEAD_0000;
    do_write(4'd7, 32'h1000, 8'd0, 2'b01, 4'hF, 1);
    checkOutput("t4 bresp", bresp, 2'b11);
    do_read(4'd4, 32'h0, 8'd0, 2'b01, 0);
    checkOutput("t4 word0 kept", rdat[0], 32'hFFBB_FFDD);
    do_read(4'd4, 32'h1000, 8'd0, 2'b01, 0);
    checkOutput("t4 oor rdata", rdat[0], 0);
    checkOutput("t4 oor rresp", rresp[0], 2'b11);
    checkOutput("t4 oor rlast", rlast[0], 1);

    // Early LAST and overrun both give SLVERR; overrun beat is dropped.
    wdat[0] = 32'h4040_0001; wdat[1] = 32'h4040_0002;
    do_write(4'd6, 32'h40, 8'd3, 2'b01, 4'hF, 2);
    checkOutput("t5 early last", bresp, 2'b10);
    wdat[0] = 32'h5454_5454;
    do_write(4'd6, 32'h54, 8'd0, 2'b01, 4'hF, 1);
    wdat[0] = 32'hA0A0_A0A0; wdat[1] = 32'hB0B0_B0B0;
    do_write(4'd6, 32'h50, 8'd0, 2'b01, 4'hF, 2);
    checkOutput("t5 overrun", bresp, 2'b10);
    do_read(4'd6, 32'h50, 8'd1, 2'b01, 0);
    checkOutput("t5 word50", rdat[0], 32'hA0A0_A0A0);
    checkOutput("t5 word54", rdat[1], 32'h5454_5454);

    // Reserved burst code behaves as INCR but flags SLVERR.
    wdat[0] = 32'hC1C1_C1C1; wdat[1] = 32'hC2C2_C2C2;
    do_write(4'd2, 32'h70, 8'd1, 2'b10, 4'hF, 2);
    checkOutput("t5 rsvd bresp", bresp, 2'b10);
    do_read(4'd2, 32'h70, 8'd1, 2'b11, 0);
    checkOutput("t5 rsvd rdata1", rdat[1], 32'hC2C2_C2C2);
    checkOutput("t5 rsvd rresp", rresp[0], 2'b10);

    // Random READY stalls.
    do_read(4'd8, 32'h10, 8'd3, 2'b01, 1);
    checkOutput("t5 stall beats", rbeats, 4);
    checkOutput("t5 stall beat3", rdat[3], 32'd4);
    checkOutput("t5 stall last", rlast[3], 1);

    // Same-word write beat and read request on one edge: read sees old word.
    wdat[0] = 32'h1111_1111;
    do_write(4'd1, 32'h60, 8'd0, 2'b01, 4'hF, 1);
    @(negedge CLK);
    WR_ADDR_ID = 4'd3; WR_ADDR = 32'h60; WR_ADDR_LEN = 8'd0; WR_ADDR_BURST = 2'b01;
    WR_ADDR_VALID = 1'b1;
    checkOutput("t6 aw ready", WR_ADDR_READY, 1);
    @(posedge CLK); @(negedge CLK);
    WR_ADDR_VALID = 1'b0;
    WR_DATA = 32'h2222_2222; WR_STRB = 4'hF; WR_DATA_LAST = 1'b1; WR_DATA_VALID = 1'b1;
    RD_ADDR_ID = 4'd4; RD_ADDR = 32'h60; RD_ADDR_LEN = 8'd0; RD_ADDR_BURST = 2'b01;
    RD_ADDR_VALID = 1'b1;
    checkOutput("t6 both ready", {WR_DATA_READY, RD_ADDR_READY}, 2'b11);
    @(posedge CLK); @(negedge CLK);
    WR_DATA_VALID = 1'b0; WR_DATA_LAST = 1'b0; RD_ADDR_VALID = 1'b0;
    checkOutput("t6 rvalid", RD_DATA_VALID, 1);
    checkOutput("t6 old word", RD_DATA, 32'h1111_1111);
    checkOutput("t6 bvalid", WR_BACK_VALID, 1);
    RD_DATA_READY = 1'b1; WR_BACK_READY = 1'b1;
    @(posedge CLK); @(negedge CLK);
    RD_DATA_READY = 1'b0; WR_BACK_READY = 1'b0;
    do_read(4'd4, 32'h60, 8'd0, 2'b01, 0);
    checkOutput("t6 new word", rdat[0], 32'h2222_2222);

    // Reset in the middle of a read burst.
    @(negedge CLK);
    RD_ADDR_ID = 4'd1; RD_ADDR = 32'h10; RD_ADDR_LEN = 8'd3; RD_ADDR_BURST = 2'b01;
    RD_ADDR_VALID = 1'b1;
    checkOutput("t7 ar ready", RD_ADDR_READY, 1);
    @(posedge CLK); @(negedge CLK);
    RD_ADDR_VALID = 1'b0; RD_DATA_READY = 1'b1;
    @(posedge CLK); @(negedge CLK);
    checkOutput("t7 beat1", RD_DATA, 32'd2);
    RD_DATA_READY = 1'b0;
    RST = 1'b1;
    #1;
    checkOutput("t7 rvalid in rst", RD_DATA_VALID, 0);
    checkOutput("t7 arready in rst", RD_ADDR_READY, 0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checkOutput("t7 arready pre-edge", RD_ADDR_READY, 0);
    @(negedge CLK);
    checkOutput("t7 arready after", RD_ADDR_READY, 1);
    checkOutput("t7 rvalid after", RD_DATA_VALID, 0);
    checkOutput("t7 bvalid after", WR_BACK_VALID, 0);
  endtask

  initial begin
    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung handshake anywhere above.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axi_slave_ram_responder.md
Name: axi_slave_ram_responder

Overview:
- Single-clock AXI slave endpoint that terminates the slave-side channels delivered by the bus/slave clock-domain bridge.
- Decodes write-address/write-data bursts into a byte-strobed on-chip RAM and returns write responses.
- Serves read-address bursts by streaming RAM words back on the read-data channel.
- Used as the generic memory-mapped scratch/BRAM slave on the lab bus.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of RAM word 0
MEM_AW, 10, RAM word-address width (depth = 2**MEM_AW 32-bit words)

Ports:
CLK  in  1  block clock
RST  in  1  asynchronous reset, active-high
WR_ADDR_ID/WR_ADDR/WR_ADDR_LEN/WR_ADDR_BURST  in  4/32/8/2  write-address fields; LEN = beats-1
WR_ADDR_VALID  in  1 ; WR_ADDR_READY  out  1
WR_DATA/WR_STRB/WR_DATA_LAST  in  32/4/1  write-data beat
WR_DATA_VALID  in  1 ; WR_DATA_READY  out  1
WR_BACK_ID/WR_BACK_RESP  out  4/2  write response
WR_BACK_VALID  out  1 ; WR_BACK_READY  in  1
RD_ADDR_ID/RD_ADDR/RD_ADDR_LEN/RD_ADDR_BURST  in  4/32/8/2  read-address fields
RD_ADDR_VALID  in  1 ; RD_ADDR_READY  out  1
RD_BACK_ID/RD_DATA/RD_DATA_RESP/RD_DATA_LAST  out  4/32/2/1  read beat
RD_DATA_VALID  out  1 ; RD_DATA_READY  in  1

Behaviour:
- Reset: one clock CLK; RST is asynchronous, active-high. While RST=1 both FSMs go to IDLE; all outputs 0 except WR_ADDR_READY=1 and RD_ADDR_READY=1 after the first clock edge once RST is low (both READYs are 0 while RST=1). RAM contents are not reset.
- Handshake rules:
  - Transfer occurs when VALID&&READY on a rising edge.
  - Output VALID/payload hold stable until accepted.
  - Payload outputs read 0 when their VALID is 0.
- Address decode:
  - word index = (ADDR-BASE_ADDR)>>2, low 2 bits ignored.
  - In range iff BASE_ADDR <= ADDR < BASE_ADDR + 4*2**MEM_AW, checked per beat.
  - Out-of-range beat: no RAM write; read data 0; resp DECERR (2'b11).
- Burst: 2'b00 FIXED (same address every beat); 2'b01 INCR (+4 per beat, 32-bit arithmetic wrap); 2'b10/2'b11 treated as INCR with resp SLVERR (2'b10).
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: WR_ADDR_READY=1; on handshake latch ID/addr/LEN/burst, clear beat counter, go to W_DATA.
  - W_DATA: WR_DATA_READY=1; each beat writes bytes where STRB=1 and advances address/counter.
  - Beat carrying LAST -> W_RESP.
  - LAST earlier than LEN+1 beats -> SLVERR.
  - Beats beyond LEN+1 without LAST are accepted but not written; burst ends at LAST with SLVERR.
  - W_RESP: WR_BACK_VALID=1, WR_BACK_ID=latched ID, RESP = worst of {OKAY 00, SLVERR 10, DECERR 11} seen in the burst (DECERR highest). On handshake return to W_IDLE.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: RD_ADDR_READY=1; handshake issues RAM read of beat 0.
  - RD_DATA_VALID rises the next cycle (1-cycle latency).
  - RAM read address = (beat handshake ? next-beat address : current address), so one beat per cycle when RD_DATA_READY=1; no bubbles.
  - RD_DATA_LAST=1 on beat LEN. Per-beat RD_DATA_RESP uses the same rules as writes. RD_BACK_ID = latched ID.
  - Handshake on LAST -> R_IDLE, RD_ADDR_READY=1 the following cycle.
- Read and write FSMs are independent and may run concurrently.
- Same-word read/write in one cycle: read returns the old word (read-first).
- LEN=0: single beat, LAST on first beat.
- RST asserted mid-burst aborts both bursts immediately; no response is issued afterwards.

Decomposition:
- Package axi_slave_pkg: RESP_OKAY/SLVERR/DECERR constants, BURST_FIXED/INCR codes, write/read state enums, and a resp "worst-of" function.
- Sub-module axi_ram_dp: simple dual-port RAM, 32-bit, byte enables, registered read, read-first, depth 2**MEM_AW.

Test Plan:
- Write INCR addr 0x10, LEN=3, data 1..4, STRB=F, then read same -> WR_BACK_RESP=00 with ID echoed; read returns 1,2,3,4, LAST on the 4th beat, one beat per cycle with READY held 1.
- Write 0xAABBCCDD to 0x0 with STRB=4'b0101 over 0xFFFFFFFF -> readback 0xFFBBFFDD.
- FIXED burst LEN=2 to 0x20, data 5,6,7 -> word 0x20 reads 7, word 0x24 unchanged.
- Write to BASE_ADDR+4*2**MEM_AW -> RESP=11, RAM unchanged; read at the same address -> data 0, RESP=11, LAST=1.
- Write LEN=3 with LAST on beat 2 -> RESP=10. Read with random RD_DATA_READY stalls -> data and LAST held stable until accepted.
- Concurrent read/write of the same word -> read sees old value. RST pulsed mid read burst -> RD_DATA_VALID=0 immediately, RD_ADDR_READY=1 one cycle after release.
